// File: rtl/seq1101_tx_pkg.sv
// seq_pkg: shared tracker state codes, the target pattern and the tracker next-state rule
package seq_pkg;

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b011,
        S3 = 3'b010,
        S4 = 3'b110
    } trk_state_t;

    localparam logic [3:0] PATTERN = 4'b1101;
    localparam int         PAT_LEN = 4;

    // Overlapping 1101 matcher; any unknown code falls back to S0
    function automatic trk_state_t trk_next(input trk_state_t s, input logic b);
        case (s)
            S0:      return (b == PATTERN[3]) ? S1 : S0;
            S1:      return (b == PATTERN[2]) ? S2 : S0;
            S2:      return (b == PATTERN[1]) ? S3 : S2;
            S3:      return (b == PATTERN[0]) ? S4 : S0;
            S4:      return b ? S2 : S0;
            default: return S0;
        endcase
    endfunction

endpackage

// File: rtl/seq1101_tx_tracker.sv
// seq_tracker: Moore FSM flagging a completed 1101 on the observed bit stream
module seq_tracker
    import seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bit_in,
    output logic hit
);

    trk_state_t r_state;
    logic       r_hit;
    trk_state_t w_next;

    assign w_next = trk_next(r_state, bit_in);
    assign hit    = r_hit;

    // Advance on every clock; hit is registered alongside the state it decodes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S0;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hit   <= (w_next == S4);
        end
    end

endmodule

// File: rtl/seq1101_tx.sv
// seq1101_tx: MSB-first serialiser with word repeat and an on-board 1101 occurrence counter
module seq1101_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             repeat_en,
    input  logic             cnt_clr,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             pat_hit,
    output logic [CNT_W-1:0] pat_cnt
);

    localparam int              BC_W = $clog2(WIDTH);
    localparam logic [BC_W-1:0] LAST = BC_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_saved;
    logic [BC_W-1:0]  r_bit_cnt;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    logic             w_take;
    logic             w_hit;

    assign w_last     = (r_bit_cnt == LAST);
    assign load_ready = ~r_valid | w_last;
    assign w_take     = load_valid & load_ready;
    assign tx_valid   = r_valid;
    assign tx_bit     = r_valid & r_shift[WIDTH-1];
    assign pat_hit    = w_hit;
    assign pat_cnt    = r_cnt;

    // Word sequencing: a new load wins at the boundary, then repeat, else go idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_saved   <= '0;
            r_bit_cnt <= '0;
            r_valid   <= 1'b0;
        end else if (w_take) begin
            r_shift   <= load_data;
            r_saved   <= load_data;
            r_bit_cnt <= '0;
            r_valid   <= 1'b1;
        end else if (r_valid && w_last) begin
            r_shift   <= repeat_en ? r_saved : '0;
            r_bit_cnt <= '0;
            r_valid   <= repeat_en;
        end else if (r_valid) begin
            r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Tracker sees tx_bit every cycle, idle zeros included, exactly like the detector
    seq_tracker u_trk (
        .clk    (clk),
        .reset  (reset),
        .bit_in (tx_bit),
        .hit    (w_hit)
    );

    // Saturating hit counter; clear beats increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (cnt_clr)
            r_cnt <= '0;
        else if (w_hit && !(&r_cnt))
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: tb/tb_seq1101_tx.sv
// tb_seq1101_tx: directed and random checks of seq1101_tx against a queue-based reference model
module tb_seq1101_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       repeat_en = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       load_ready, tx_bit, tx_valid, pat_hit;
    logic [7:0] pat_cnt;
    logic       load_ready2, tx_bit2, tx_valid2, pat_hit2;
    logic [1:0] pat_cnt2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq1101_tx #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .repeat_en(repeat_en), .cnt_clr(cnt_clr),
        .tx_bit(tx_bit), .tx_valid(tx_valid), .pat_hit(pat_hit), .pat_cnt(pat_cnt)
    );

    seq1101_tx #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready2),
        .load_data(load_data), .repeat_en(repeat_en), .cnt_clr(cnt_clr),
        .tx_bit(tx_bit2), .tx_valid(tx_valid2), .pat_hit(pat_hit2), .pat_cnt(pat_cnt2)
    );

    // Reference: queue of bits still to send (head = bit on the wire now) and a 4-bit history
    bit         q[$];
    logic [7:0] m_saved = 8'h00;
    logic [3:0] m_hist = 4'h0;
    int         m_cnt8 = 0;
    int         m_cnt2 = 0;

    function automatic logic m_valid();
        return q.size() > 0;
    endfunction

    function automatic logic m_bit();
        return (q.size() > 0) ? q[0] : 1'b0;
    endfunction

    function automatic logic m_ready();
        return q.size() <= 1;
    endfunction

    function automatic logic m_hit();
        return m_hist == 4'b1101;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                q.delete();
                m_saved = 8'h00;
                m_hist  = 4'h0;
                m_cnt8  = 0;
                m_cnt2  = 0;
            end else begin
                automatic logic hit  = m_hit();
                automatic logic cur  = m_bit();
                automatic int   size = q.size();
                automatic logic take = load_valid && (size <= 1);
                m_hist = {m_hist[2:0], cur};
                if (cnt_clr) begin
                    m_cnt8 = 0;
                    m_cnt2 = 0;
                end else if (hit) begin
                    m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                    m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
                end
                if (size > 0) void'(q.pop_front());
                if (take) begin
                    for (int i = 7; i >= 0; i--) q.push_back(load_data[i]);
                    m_saved = load_data;
                end else if (size == 1 && repeat_en) begin
                    for (int i = 7; i >= 0; i--) q.push_back(m_saved[i]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_valid()});
            chk("tx_bit", {31'b0, tx_bit}, {31'b0, m_bit()});
            chk("load_ready", {31'b0, load_ready}, {31'b0, m_ready()});
            chk("pat_hit", {31'b0, pat_hit}, {31'b0, m_hit()});
            chk("pat_cnt", {24'b0, pat_cnt}, 32'(m_cnt8));
            chk("pat_cnt2", {30'b0, pat_cnt2}, 32'(m_cnt2));
            chk("tx_bit2", {31'b0, tx_bit2}, {31'b0, m_bit()});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && tx_valid; i++) cyc();
        chk("idle_reached", {31'b0, tx_valid}, 32'd0);
    endtask

    initial begin
        logic [7:0] e;
        int         loads;
        int         cycles;
        #12;
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_tx_bit", {31'b0, tx_bit}, 32'd0);
        chk("rst_pat_cnt", {24'b0, pat_cnt}, 32'd0);
        chk("rst_ready", {31'b0, load_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single word 1101_0000
        load_valid = 1'b1;
        load_data  = 8'hD0;
        cyc();
        load_valid = 1'b0;
        e = 8'hD0;
        for (int k = 1; k <= 8; k++) begin
            chk("t1_valid", {31'b0, tx_valid}, 32'd1);
            chk("t1_bit", {31'b0, tx_bit}, {31'b0, e[8-k]});
            chk("t1_hit", {31'b0, pat_hit}, {31'b0, k == 5});
            chk("t1_ready", {31'b0, load_ready}, {31'b0, k == 8});
            cyc();
        end
        chk("t1_idle", {31'b0, tx_valid}, 32'd0);
        chk("t1_cnt", {24'b0, pat_cnt}, 32'd1);

        // Back-to-back DD, B6
        cnt_clr = 1'b1;
        cyc();
        cnt_clr    = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hDD;
        cyc();
        load_data = 8'hB6;
        for (int k = 1; k <= 16; k++) begin
            if (k == 9) load_valid = 1'b0;
            chk("t2_gapless", {31'b0, tx_valid}, 32'd1);
            cyc();
        end
        chk("t2_idle", {31'b0, tx_valid}, 32'd0);
        chk("t2_cnt", {24'b0, pat_cnt}, 32'd4);
        chk("t2_cnt2_sat", {30'b0, pat_cnt2}, 32'd3);

        // 0D repeated: one hit per repetition
        cnt_clr = 1'b1;
        cyc();
        cnt_clr    = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'h0D;
        repeat_en  = 1'b1;
        cyc();
        load_valid = 1'b0;
        run(8);
        chk("t3_cnt_rep1", {24'b0, pat_cnt}, 32'd0);
        chk("t3_hit_rep1", {31'b0, pat_hit}, 32'd1);
        run(16);
        chk("t3_hit_rep3", {31'b0, pat_hit}, 32'd1);
        chk("t3_cnt_rep2", {24'b0, pat_cnt}, 32'd2);
        cyc();
        chk("t3_cnt_rep3", {24'b0, pat_cnt}, 32'd3);

        // DD repeated: narrow counter saturates, clear beats a coincident hit
        load_valid = 1'b1;
        load_data  = 8'hDD;
        for (int i = 0; i < 20 && !load_ready; i++) cyc();
        cyc();
        load_valid = 1'b0;
        run(40);
        chk("t5_sat", {30'b0, pat_cnt2}, 32'd3);
        chk("t5_still_valid", {31'b0, tx_valid}, 32'd1);
        for (int i = 0; i < 16 && !m_hit(); i++) cyc();
        chk("t5_hit_found", {31'b0, pat_hit}, 32'd1);
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        chk("t5_clr_cnt", {24'b0, pat_cnt}, 32'd0);
        chk("t5_clr_cnt2", {30'b0, pat_cnt2}, 32'd0);
        repeat_en = 1'b0;
        run(5);
        wait_idle();

        // Async reset in bit 3 of FF
        load_valid = 1'b1;
        load_data  = 8'hFF;
        cyc();
        load_valid = 1'b0;
        run(2);
        #2;
        reset = 1'b0;
        #1;
        chk("t4_async_valid", {31'b0, tx_valid}, 32'd0);
        chk("t4_async_bit", {31'b0, tx_bit}, 32'd0);
        chk("t4_async_hit", {31'b0, pat_hit}, 32'd0);
        chk("t4_async_cnt", {24'b0, pat_cnt}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("t4_ready", {31'b0, load_ready}, 32'd1);
        cyc();
        chk("t4_no_resume", {31'b0, tx_valid}, 32'd0);

        // Random loads with random gaps, repeat and clears
        loads  = 0;
        cycles = 0;
        while (loads < 1000 && cycles < 30000) begin
            load_valid = ($urandom_range(0, 2) != 0);
            load_data  = 8'($urandom);
            repeat_en  = ($urandom_range(0, 7) == 0);
            cnt_clr    = ($urandom_range(0, 63) == 0);
            if (load_valid && load_ready) loads++;
            cyc();
            cycles++;
        end
        chk("t6_loads_done", 32'(loads), 32'd1000);
        load_valid = 1'b0;
        repeat_en  = 1'b0;
        cnt_clr    = 1'b0;
        run(10);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
